// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared definitions for the cache memory responder.
//   TYPE_*     : request size encodings carried on rd_type / wr_type
//   r_state_t  : read FSM states (R_IDLE, R_WAIT, R_BEAT)
//   w_state_t  : write FSM states (W_IDLE, W_BUSY)
//   type_beats : number of return beats a request type produces
package cache_mem_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_BEAT = 2'd2
  } r_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } w_state_t;

  // A line moves four words; every other size moves one aligned word.
  function automatic logic [2:0] type_beats(input logic [2:0] t);
    logic [2:0] n;
    case (t)
      TYPE_LINE:                       n = 3'd4;
      TYPE_BYTE, TYPE_HALF, TYPE_WORD: n = 3'd1;
      default:                         n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cache_mem_responder_lfsr.sv
// resp_lfsr: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seeded 16'hACE1
// on reset and stepped every clock. Drives random beat back-pressure.
// Only present when RESP_BACKPRESSURE_EN is defined.
//   clk    : clock
//   resetn : synchronous active-low reset (reloads the seed)
//   lfsr   : current LFSR state
`ifdef RESP_BACKPRESSURE_EN
module resp_lfsr (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] lfsr
);

  logic feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

endmodule
`endif

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: behavioural backing store answering cache refill
// reads and write-backs with fixed latencies.
//   clk, resetn                 : clock, synchronous active-low reset
//   rd_req/rd_type/rd_addr      : read request (accepted when rd_rdy is high)
//   rd_rdy                      : read FSM idle
//   ret_valid/ret_last/ret_data : registered return beats, ret_last[0] on final beat
//   wr_req/wr_type/wr_addr      : write request (accepted when wr_rdy is high)
//   wr_wstrb/wr_data            : byte mask (non-line) and data (word n in [32n+31:32n])
//   wr_rdy                      : write FSM idle
//   dbg_rd_state/dbg_wr_state   : current read / write FSM state
// Handshake: a request transfers in any cycle where req and rdy are both high;
// rdy does not depend on req, and req/type/addr/data are sampled only then.
// Optional feature: define RESP_BACKPRESSURE_EN to withhold beats randomly
// (LFSR driven); beat count and order are unchanged.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [1:0]   ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [1:0]   dbg_rd_state,
  output logic         dbg_wr_state
);

  localparam int         AW           = $clog2(MEM_WORDS);
  localparam logic [3:0] RD_LAST_WAIT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LAST_BUSY = 4'(WR_LAT);

  // Storage holds data XOR (index*4). An all-zero array therefore reads back
  // as index*4, giving the documented power-up image without any
  // initialisation logic, and reset never touches the array.
  logic [31:0] mem_raw [MEM_WORDS];

  function automatic logic [31:0] addr_key(input logic [AW-1:0] idx);
    return 32'({idx, 2'b00});
  endfunction

  // ---------------- write side ----------------
  w_state_t      w_state_q, w_state_d;
  logic [3:0]    w_cnt_q, w_cnt_d;
  logic          wr_fire, wr_line;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_key;

  assign wr_rdy  = resetn && (w_state_q == W_IDLE);
  assign wr_fire = wr_req && wr_rdy;
  assign wr_line = (type_beats(wr_type) == 3'd4);
  assign wr_idx  = wr_addr[AW+1:2];
  assign wr_key  = addr_key(wr_idx);

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_fire) begin
          w_state_d = W_BUSY;
          w_cnt_d   = 4'd1;
        end
      end
      W_BUSY: begin
        if (w_cnt_q == WR_LAST_BUSY) begin
          w_state_d = W_IDLE;
          w_cnt_d   = 4'd0;
        end else begin
          w_cnt_d = w_cnt_q + 4'd1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        w_cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= 4'd0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_line) begin
        for (int n = 0; n < 4; n++) begin
          mem_raw[{wr_idx[AW-1:2], 2'(n)}] <= wr_data[32*n +: 32] ^ addr_key({wr_idx[AW-1:2], 2'(n)});
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wr_wstrb[b]) begin
            mem_raw[wr_idx][8*b +: 8] <= wr_data[8*b +: 8] ^ wr_key[8*b +: 8];
          end
        end
      end
    end
  end

  // ---------------- read side ----------------
  r_state_t      r_state_q, r_state_d;
  logic [3:0]    r_cnt_q, r_cnt_d;
  logic [2:0]    beats_q, beats_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          rd_line_q, rd_line_d;
  logic          rd_fire, src_line, try_beat, beat_hold;
  logic [AW-1:0] src_idx, beat_idx;
  logic [2:0]    total_beats;
  logic [31:0]   rd_word;
  logic          ret_valid_d;
  logic [1:0]    ret_last_d;
  logic [31:0]   ret_data_d;

  assign rd_rdy  = resetn && (r_state_q == R_IDLE);
  assign rd_fire = rd_req && rd_rdy;

  // With RD_LAT=1 the first beat is fetched in the accept cycle, so the
  // live request fields are used while idle.
  always_comb begin
    src_idx     = (r_state_q == R_IDLE) ? rd_addr[AW+1:2] : rd_idx_q;
    src_line    = (r_state_q == R_IDLE) ? (type_beats(rd_type) == 3'd4) : rd_line_q;
    total_beats = src_line ? 3'd4 : 3'd1;
    beat_idx    = src_line ? {src_idx[AW-1:2], beats_q[1:0]} : src_idx;
  end

  // Forward a write accepted in the same cycle so reads see post-write data.
  always_comb begin
    rd_word = mem_raw[beat_idx] ^ addr_key(beat_idx);
    if (wr_fire) begin
      if (wr_line) begin
        if (beat_idx[AW-1:2] == wr_idx[AW-1:2]) begin
          rd_word = wr_data[{beat_idx[1:0], 5'b00000} +: 32];
        end
      end else if (beat_idx == wr_idx) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_wstrb[b]) begin
            rd_word[8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;

  resp_lfsr u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .lfsr   (lfsr)
  );

  assign beat_hold   = lfsr[0];
  assign unused_lfsr = ^lfsr[15:1];
`else
  assign beat_hold = 1'b0;
`endif

  // Outputs are registered: the cycle that decides a beat loads it, so the
  // beat is visible exactly while the FSM sits in R_BEAT afterwards.
  always_comb begin
    r_state_d   = r_state_q;
    r_cnt_d     = r_cnt_q;
    beats_d     = beats_q;
    rd_idx_d    = rd_idx_q;
    rd_line_d   = rd_line_q;
    try_beat    = 1'b0;
    ret_valid_d = 1'b0;
    ret_last_d  = 2'b00;
    ret_data_d  = ret_data;
    case (r_state_q)
      R_IDLE: begin
        if (rd_fire) begin
          rd_idx_d  = rd_addr[AW+1:2];
          rd_line_d = src_line;
          beats_d   = 3'd0;
          if (RD_LAT == 1) begin
            r_state_d = R_BEAT;
            try_beat  = 1'b1;
          end else begin
            r_state_d = R_WAIT;
            r_cnt_d   = 4'd1;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == RD_LAST_WAIT) begin
          r_state_d = R_BEAT;
          r_cnt_d   = 4'd0;
          try_beat  = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q + 4'd1;
        end
      end
      R_BEAT: begin
        if (beats_q == total_beats) begin
          r_state_d = R_IDLE;
          beats_d   = 3'd0;
        end else begin
          try_beat = 1'b1;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        r_cnt_d   = 4'd0;
        beats_d   = 3'd0;
      end
    endcase
    if (try_beat && !beat_hold) begin
      ret_valid_d = 1'b1;
      ret_data_d  = rd_word;
      ret_last_d  = {1'b0, (beats_q + 3'd1) == total_beats};
      beats_d     = beats_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      beats_q   <= 3'd0;
      rd_idx_q  <= '0;
      rd_line_q <= 1'b0;
      ret_valid <= 1'b0;
      ret_last  <= 2'b00;
      ret_data  <= 32'd0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      beats_q   <= beats_d;
      rd_idx_q  <= rd_idx_d;
      rd_line_q <= rd_line_d;
      ret_valid <= ret_valid_d;
      ret_last  <= ret_last_d;
      ret_data  <= ret_data_d;
    end
  end

  assign dbg_rd_state = r_state_q;
  assign dbg_wr_state = w_state_q;

  // Address bits outside the word index select nothing.
  logic unused_addr;
  assign unused_addr = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, backing-store depth in 32-bit words (power of two).
REQ-002 SHALL have parameter RD_LAT, default 2, cycles from read acceptance to first ret_valid (legal range 1..15).
REQ-003 SHALL have parameter WR_LAT, default 3, cycles wr_rdy stays low after write acceptance (legal range 1..15).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rd_req  input  1  read request.
REQ-007 SHALL have port rd_type  input  3  000 byte, 001 half, 010 word, 100 line.
REQ-008 SHALL have port rd_addr  input  32  read start byte address.
REQ-009 SHALL have port rd_rdy  output  1  read request accepted this cycle if rd_req high.
REQ-010 SHALL have port ret_valid  output  1  return beat valid.
REQ-011 SHALL have port ret_last  output  2  bit0 marks last beat; bit1 always 0.
REQ-012 SHALL have port ret_data  output  32  return beat data.
REQ-013 SHALL have port wr_req  input  1  write request.
REQ-014 SHALL have port wr_type  input  3  encoding as rd_type.
REQ-015 SHALL have port wr_addr  input  32  write start byte address.
REQ-016 SHALL have port wr_wstrb  input  4  byte mask for non-line writes.
REQ-017 SHALL have port wr_data  input  128  write data; word n in bits [32n+31:32n].
REQ-018 SHALL have port wr_rdy  output  1  write request accepted this cycle if wr_req high.

Function
REQ-019 Read accepted in cycle k iff rd_req & rd_rdy; rd_type/rd_addr sampled then.
REQ-020 Read FSM states R_IDLE, R_WAIT, R_BEAT; R_IDLE->R_WAIT on accept; R_WAIT->R_BEAT when latency counter reaches RD_LAT-1; R_BEAT->R_IDLE after final beat.
REQ-021 rd_rdy high only in R_IDLE; first ret_valid in cycle k+RD_LAT; rd_rdy high again the cycle after the last beat.
REQ-022 Line read: 4 beats, word n at {rd_addr[31:4], n[1:0], 2'b00}, order n=0..3, ret_last[0] on beat 3 only.
REQ-023 Non-line read: 1 beat, full aligned word at rd_addr[31:2], ret_last[0]=1.
REQ-024 Word index = byte address[31:2] modulo MEM_WORDS (silent wrap).
REQ-025 Write accepted in cycle k iff wr_req & wr_rdy; memory updated at end of cycle k.
REQ-026 Write FSM states W_IDLE, W_BUSY; wr_rdy low cycles k+1..k+WR_LAT, high at k+WR_LAT+1.
REQ-027 Line write stores all 4 words of wr_data, all bytes; non-line write stores wr_data[31:0] to word wr_addr[31:2] under wr_wstrb.
REQ-028 Read and write FSMs independent; rd and wr accepted same cycle: read returns post-write data.
REQ-029 ret_data, ret_valid, ret_last registered; ret_data don't-care when ret_valid low.

Reset
REQ-030 While resetn low: rd_rdy=0, wr_rdy=0, ret_valid=0, ret_last=2'b00, ret_data=0, FSMs to R_IDLE/W_IDLE, counters 0.
REQ-031 Reset mid-burst or mid-busy aborts the operation; no further beats after resetn deasserts.
REQ-032 Memory contents unaffected by reset; simulation initial value of word i is i*4.

Configuration
REQ-033 Macro RESP_BACKPRESSURE_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) steps every cycle; in R_BEAT, beat withheld (ret_valid=0) when lfsr[0]=1; beat count and order unchanged.
REQ-034 Macro undefined: line beats on 4 consecutive cycles, no LFSR logic.

Structure
REQ-035 Package cache_mem_pkg holds type constants (TYPE_BYTE/HALF/WORD/LINE) and R_*/W_* state encodings.
REQ-036 One sub-module resp_lfsr, instantiated only under RESP_BACKPRESSURE_EN.

Verification
REQ-037 Line read 0x00000040, RD_LAT=2, accept cycle 0 -> ret_valid cycles 2..5, data 0x40,0x44,0x48,0x4C, ret_last=01 at cycle 5 only.
REQ-038 Line write 0x80 with data {D3,D2,D1,D0}, then line read 0x80 -> D0..D3; wr_rdy low exactly 3 cycles.
REQ-039 Word write 0x100, type 010, wstrb 0011, data 0xAABBCCDD, then word read 0x100 -> one beat 0x0000CCDD, ret_last=01.
REQ-040 Same-cycle rd_req and wr_req, line 0x200 -> read returns new write data.
REQ-041 resetn low after beat 1 of a line read -> ret_valid 0 during reset, rd_rdy 1 first cycle after release, no stray beats.
REQ-042 With RESP_BACKPRESSURE_EN, 100 random line reads -> exactly 4 beats each, correct order, ret_last only on 4th beat.
